// File: rtl/fifo_param_if.sv
// Bus bundle between the packet source and fifo_param.
// Carries write/read requests, thresholds, error clear and all status outputs.
// master = source/consumer side, slave = FIFO side.
interface fifo_param_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic [DW-1:0] data_in;
  logic          push;
  logic          pop;
  logic [AW:0]   umbral_almost_full;
  logic [AW:0]   umbral_almost_empty;
  logic          error_clr;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          fifo_full;
  logic          fifo_empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   fill_level;
  logic          error;
  logic [AW:0]   max_level;

  modport master (
    output data_in, push, pop, umbral_almost_full, umbral_almost_empty, error_clr,
    input  data_out, valid_out, fifo_full, fifo_empty, almost_full, almost_empty,
           fill_level, error, max_level
  );

  modport slave (
    input  data_in, push, pop, umbral_almost_full, umbral_almost_empty, error_clr,
    output data_out, valid_out, fifo_full, fifo_empty, almost_full, almost_empty,
           fill_level, error, max_level
  );
endinterface

// File: rtl/fifo_param.sv
// Synchronous FIFO, 2**AW x DW, with fill level, threshold flags and sticky error.
// Latency: registered read data one cycle after an effective pop; flags combinational on fill level.
// Backpressure: push while full without a same-cycle pop is dropped and flags error; pop while empty flags error.
// Optional FIFO_WATERMARK_EN: max_level tracks peak occupancy; otherwise tied to 0.
module fifo_param #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  fifo_param_if.slave bus
);

  localparam logic [AW:0] LP_DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_fill_level;
  logic [DW-1:0] r_data_out;
  logic          r_valid_out;
  logic          r_error;

  logic          w_full;
  logic          w_empty;
  logic          w_pop_eff;
  logic          w_push_acc;
  logic          w_err_evt;
  logic [AW:0]   w_fill_nxt;

  assign w_full     = (r_fill_level == LP_DEPTH);
  assign w_empty    = (r_fill_level == '0);
  assign w_pop_eff  = bus.pop && !w_empty;
  // A full FIFO still accepts a push when a word leaves on the same edge.
  assign w_push_acc = bus.push && (!w_full || w_pop_eff);
  // Overflow: push refused. Underflow: pop on empty (a same-cycle push does not rescue it).
  assign w_err_evt  = (bus.push && !w_push_acc) || (bus.pop && w_empty);

  // Next occupancy from the accepted push / effective pop pair.
  always_comb begin
    w_fill_nxt = r_fill_level;
    case ({w_push_acc, w_pop_eff})
      2'b10:   w_fill_nxt = r_fill_level + (AW+1)'(1);
      2'b01:   w_fill_nxt = r_fill_level - (AW+1)'(1);
      default: w_fill_nxt = r_fill_level;
    endcase
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  // Pointers and occupancy; pointers wrap naturally on AW bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill_level <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_eff)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_fill_level <= w_fill_nxt;
    end
  end

  // Registered read port: data_out holds its last value when no word is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_pop_eff;
      if (w_pop_eff) r_data_out <= r_mem[r_rd_ptr];
    end
  end

  // Sticky error; a new event on the same edge as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (w_err_evt) begin
      r_error <= 1'b1;
    end else if (bus.error_clr) begin
      r_error <= 1'b0;
    end
  end

`ifdef FIFO_WATERMARK_EN
  logic [AW:0] r_max_level;

  // Peak occupancy; error_clr restarts the watermark from the present level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max_level <= '0;
    end else if (bus.error_clr) begin
      r_max_level <= r_fill_level;
    end else if (w_fill_nxt > r_max_level) begin
      r_max_level <= w_fill_nxt;
    end
  end

  assign bus.max_level = r_max_level;
`else
  assign bus.max_level = '0;
`endif

  assign bus.data_out     = r_data_out;
  assign bus.valid_out    = r_valid_out;
  assign bus.fifo_full    = w_full;
  assign bus.fifo_empty   = w_empty;
  // Unsigned AW+1-bit compares: out-of-range thresholds pin the flags naturally.
  assign bus.almost_full  = (r_fill_level >= bus.umbral_almost_full);
  assign bus.almost_empty = (r_fill_level <= bus.umbral_almost_empty);
  assign bus.fill_level   = r_fill_level;
  assign bus.error        = r_error;

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;

  fifo_param_if #(.DW(DW), .AW(AW)) bus ();

  fifo_param #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_vld;
  logic       m_err;
  int         m_max;
  int         thr_af;
  int         thr_ae;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_vld  = 1'b0;
    m_err  = 1'b0;
    m_max  = 0;
  endtask

  task automatic model_edge(input bit p, input bit o, input logic [7:0] d, input bit c);
    int  sz_before;
    bit  pop_ok;
    bit  push_ok;
    sz_before = q.size();
    pop_ok  = o && (sz_before > 0);
    push_ok = p && ((sz_before < DEPTH) || pop_ok);
    if (pop_ok) begin
      m_dout = q.pop_front();
      m_vld  = 1'b1;
    end else begin
      m_vld  = 1'b0;
    end
    if (push_ok) q.push_back(d);
    if ((p && !push_ok) || (o && !pop_ok)) m_err = 1'b1;
    else if (c) m_err = 1'b0;
`ifdef FIFO_WATERMARK_EN
    if (c) m_max = sz_before;
    else if (q.size() > m_max) m_max = q.size();
`endif
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("data_out",     32'(bus.data_out),     32'(m_dout));
    chk("valid_out",    32'(bus.valid_out),    32'(m_vld));
    chk("fifo_full",    32'(bus.fifo_full),    32'(sz == DEPTH));
    chk("fifo_empty",   32'(bus.fifo_empty),   32'(sz == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(sz >= thr_af));
    chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= thr_ae));
    chk("fill_level",   32'(bus.fill_level),   32'(sz));
    chk("error",        32'(bus.error),        32'(m_err));
    chk("max_level",    32'(bus.max_level),    32'(m_max));
  endtask

  task automatic set_thr(input int af, input int ae);
    thr_af = af;
    thr_ae = ae;
    bus.umbral_almost_full  = 4'(af);
    bus.umbral_almost_empty = 4'(ae);
  endtask

  // Called at a negedge: drive, clock, update model, check at next negedge.
  task automatic step(input bit p, input bit o, input logic [7:0] d, input bit c);
    bus.push      = p;
    bus.pop       = o;
    bus.data_in   = d;
    bus.error_clr = c;
    @(posedge clk);
    model_edge(p, o, d, c);
    @(negedge clk);
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.error_clr = 1'b0;
    check_all();
  endtask

  initial begin
    reset         = 1'b1;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.data_in   = '0;
    bus.error_clr = 1'b0;
    set_thr(6, 2);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Fill 0x11..0x18; almost_full rises at level 6.
    for (int i = 1; i <= 8; i++) step(1, 0, 8'(8'h10 + i), 0);
    chk("full_after_fill", 32'(bus.fifo_full), 32'd1);

    // Drain in order; almost_empty rises at level 2.
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);
    chk("empty_after_drain", 32'(bus.fifo_empty), 32'd1);

    // Overflow drop, then push+pop at full.
    for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom), 0);
    step(1, 0, 8'hAA, 0);
    chk("overflow_err", 32'(bus.error), 32'd1);
    step(1, 1, 8'hBB, 0);
    chk("full_pushpop_level", 32'(bus.fill_level), 32'd8);
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);
    chk("last_is_bb", 32'(bus.data_out), 32'hBB);

    // Underflow with simultaneous push: no bypass, push kept.
    step(1, 1, 8'h5C, 0);
    chk("underflow_vld", 32'(bus.valid_out), 32'd0);
    step(0, 1, 8'h00, 0);
    chk("pop_5c", 32'(bus.data_out), 32'h5C);

    // Clear collides with a fresh underflow: set wins; then clear alone.
    step(0, 1, 8'h00, 1);
    chk("clr_vs_set", 32'(bus.error), 32'd1);
    step(0, 0, 8'h00, 1);
    chk("clr_alone", 32'(bus.error), 32'd0);

    // Pointer wrap, then asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i), 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h70 + i), 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    step(0, 1, 8'h00, 0);
    step(1, 0, 8'h99, 0);
    step(0, 1, 8'h00, 0);

    // Thresholds beyond depth pin the flags.
    set_thr(9, 12);
    for (int i = 0; i < 9; i++) step(1, 0, 8'($urandom), 0);
    set_thr(0, 0);
    #1;
    check_all();
    for (int i = 0; i < 9; i++) step(0, 1, 8'h00, 0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      if ((i % 37) == 0) set_thr($urandom_range(0, 10), $urandom_range(0, 10));
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
           8'($urandom), ($urandom_range(0, 99) < 8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Next-generation synchronous FIFO with data width, depth and threshold width all parametrised.
- Adds to the previous FIFO generation:
  - separate almost_full / almost_empty flags (replacing the single combined almost_empty_full output);
  - explicit full flag and live fill-level output;
  - sticky overflow/underflow error with clear;
  - defined simultaneous push/pop behaviour at the full and empty boundaries.
- Sits between the packet source and the downstream consumer. Drop-in target for the existing probador/banco_pruebas flow with a conductual-vs-synthesised comparison.

Parameters:
- DW, 8: data width in bits.
- AW, 3: address width; depth = 2**AW entries.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- data_in  in  DW  write data.
- push  in  1  write request.
- pop  in  1  read request.
- umbral_almost_full  in  AW+1  almost_full threshold, entries.
- umbral_almost_empty  in  AW+1  almost_empty threshold, entries.
- error_clr  in  1  clears the sticky error flag.
- data_out  out  DW  registered read data.
- valid_out  out  1  data_out holds a word popped last cycle.
- fifo_full  out  1  fill_level == 2**AW.
- fifo_empty  out  1  fill_level == 0.
- almost_full  out  1  fill_level >= umbral_almost_full.
- almost_empty  out  1  fill_level <= umbral_almost_empty.
- fill_level  out  AW+1  current occupancy, 0..2**AW.
- error  out  1  sticky overflow/underflow indicator.
- max_level  out  AW+1  peak occupancy (see Optional Feature).

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - wr_ptr = rd_ptr = 0, fill_level = 0;
  - data_out = 0, valid_out = 0, error = 0, max_level = 0;
  - fifo_empty = 1, fifo_full = 0, almost_full = 0 (unless threshold is 0), almost_empty = 1.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all queued data. The next cycle after deassertion behaves as empty.
- Pointers: AW bits each, natural wrap from 2**AW-1 to 0. Occupancy is tracked by fill_level, never inferred from pointer equality alone.
- Push accept: push && (!fifo_full || pop_eff). Write data_in at wr_ptr, then wr_ptr+1.
- Push when full and no effective pop: word dropped, pointers unchanged, error set next edge.
- Pop effective: pop && !fifo_empty.
  - Next edge: data_out <= mem[rd_ptr], rd_ptr+1, valid_out = 1.
  - Read latency is 1 cycle.
- Pop when empty: valid_out = 0, data_out holds its previous value, error set.
  - This holds even if a push occurs in the same cycle; there is no bypass path.
  - The push is still accepted.
- valid_out = 0 on any cycle without an effective pop.
- fill_level update per edge:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous accepted push and effective pop, including when full (both succeed).
- Flags: combinational from registered fill_level and live threshold inputs.
  - Thresholds may change at any time; flags follow the same cycle.
- Error: set on any overflow or underflow event; held until error_clr.
  - If error_clr and a new error event occur on the same edge, set wins.
- Width rule: thresholds compared unsigned on AW+1 bits.
  - A threshold above 2**AW makes almost_full permanently 0.
  - A threshold above 2**AW makes almost_empty permanently 1.

Optional Feature:
- Macro: FIFO_WATERMARK_EN.
- Defined: max_level is a register.
  - Updates to the new fill_level whenever that exceeds the current max_level.
  - Reset to 0 by reset.
  - Reloaded with the current fill_level on error_clr.
- Undefined: max_level is tied to 0; no extra registers are synthesised.
- All other behaviour is identical in both builds.

Test Plan (DW=8, AW=3, depth 8):
- Reset, then push 0x11..0x18 on 8 consecutive cycles -> fill_level 8, fifo_full=1, fifo_empty=0, error=0.
  - With umbral_almost_full=6, almost_full rises on the edge where fill_level reaches 6.
- From full, pop 8 cycles -> data_out 0x11..0x18 each one cycle after its pop, valid_out=1 for 8 cycles, then fifo_empty=1.
  - With umbral_almost_empty=2, almost_empty rises when fill_level reaches 2.
- Full FIFO, push 0xAA alone -> dropped, error=1 next cycle, fill_level stays 8. Next cycle, push 0xBB with pop -> pop returns the oldest word, 0xBB is accepted, fill_level stays 8.
- Empty FIFO, pop and push 0x5C in the same cycle -> valid_out=0, error=1, fill_level=1. Pop next cycle -> data_out=0x5C, valid_out=1.
- Error set, then error_clr together with a fresh underflow -> error stays 1. error_clr alone next cycle -> error=0.
- Push 5 words, pop 5 words, push 6 words (forces pointer wrap), then assert reset mid-stream -> all outputs return to reset values asynchronously.
  - With FIFO_WATERMARK_EN: max_level = 6 before reset and 0 after.
